vector_fifo: RTL and testbench

- Parametrised successor to the serial-bit vector buffer.
- Deserialises a 1-bit input stream into VEC_W-bit vectors and stores them in a DEPTH-entry ring FIFO. A consumer pulls vectors with a request/valid handshake.
- Adds explicit full/empty/count status, input backpressure, selectable bit order and a synchronous flush.
- Sits between the serial bit source and the vector-processing datapath.

---
 rtl/vector_fifo.sv | 155 +++++++++++++++
 tb/tb_vector_fifo.sv | 332 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vector_fifo.sv
`default_nettype none
// ============================================================================
// Module   : vector_fifo
// Purpose  : Deserialises a 1-bit stream into VEC_W-bit vectors and stores
//            them in a DEPTH-entry ring FIFO. Consumer pops with req and gets
//            a one-cycle valid pulse with the vector one cycle later.
// Ports    : clk, rst_n (async, active-low), flush (sync clear)
//            bit_in/bit_valid/bit_ready : serial producer handshake
//            req/vector/valid           : consumer pop handshake
//            full/empty/count           : registered FIFO status
//            drop_cnt                   : refused-bit counter (optional)
// Options  : define VECTOR_FIFO_DROP_CNT_EN to add drop_cnt[7:0]
// Revision : 1.0 - initial release
// ============================================================================
module vector_fifo #(
  parameter int unsigned VEC_W     = 8,
  parameter int unsigned DEPTH     = 16,
  parameter int unsigned MSB_FIRST = 1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     flush,
  input  logic                     bit_in,
  input  logic                     bit_valid,
  output logic                     bit_ready,
  input  logic                     req,
  output logic [VEC_W-1:0]         vector,
  output logic                     valid,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
`ifdef VECTOR_FIFO_DROP_CNT_EN
  ,
  output logic [7:0]               drop_cnt
`endif
);

  localparam int unsigned ADDR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W  = ADDR_W + 1;
  localparam int unsigned FILL_W = (VEC_W > 2) ? $clog2(VEC_W) : 1;

  localparam logic [FILL_W-1:0] LAST_FILL = FILL_W'(VEC_W - 1);
  localparam logic [CNT_W-1:0]  FULL_CNT  = CNT_W'(DEPTH);

  logic [VEC_W-1:0]  ring_q [DEPTH];
  logic [VEC_W-1:0]  asm_q;
  logic [VEC_W-1:0]  asm_d;
  logic [FILL_W-1:0] fill_q;
  logic [ADDR_W-1:0] wr_ptr_q;
  logic [ADDR_W-1:0] rd_ptr_q;
  logic [CNT_W-1:0]  count_q;
  logic [CNT_W-1:0]  count_d;
  logic              full_q;
  logic              empty_q;
  logic [VEC_W-1:0]  vector_q;
  logic              valid_q;

  logic              accept;
  logic              push;
  logic              pop;

  // flush dominates every same-cycle action
  assign bit_ready = !full_q;
  assign accept    = bit_valid && bit_ready && !flush;
  assign push      = accept && (fill_q == LAST_FILL);
  assign pop       = req && !empty_q && !flush;

  generate
    if (MSB_FIRST != 0) begin : g_msb_first
      assign asm_d = {asm_q[VEC_W-2:0], bit_in};
    end else begin : g_lsb_first
      assign asm_d = {bit_in, asm_q[VEC_W-1:1]};
    end
  endgenerate

  always_comb begin
    count_d = count_q;
    if (flush) begin
      count_d = '0;
    end else if (push && !pop) begin
      count_d = count_q + 1'b1;
    end else if (pop && !push) begin
      count_d = count_q - 1'b1;
    end
  end

  // Storage is intentionally not reset; validity is tracked by count.
  always_ff @(posedge clk) begin
    if (push) begin
      ring_q[wr_ptr_q] <= asm_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      asm_q    <= '0;
      fill_q   <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
      vector_q <= '0;
      valid_q  <= 1'b0;
    end else begin
      count_q <= count_d;
      full_q  <= (count_d == FULL_CNT);
      empty_q <= (count_d == '0);
      valid_q <= pop;
      vector_q <= pop ? ring_q[rd_ptr_q] : '0;
      if (flush) begin
        asm_q    <= '0;
        fill_q   <= '0;
        wr_ptr_q <= '0;
        rd_ptr_q <= '0;
      end else begin
        if (accept) begin
          asm_q  <= asm_d;
          fill_q <= push ? '0 : fill_q + 1'b1;
        end
        if (push) begin
          wr_ptr_q <= wr_ptr_q + 1'b1;
        end
        if (pop) begin
          rd_ptr_q <= rd_ptr_q + 1'b1;
        end
      end
    end
  end

`ifdef VECTOR_FIFO_DROP_CNT_EN
  logic [7:0] drop_q;

  // Counts cycles where the producer offered a bit while we were full.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      drop_q <= '0;
    end else if (flush) begin
      drop_q <= '0;
    end else if (bit_valid && !bit_ready && (drop_q != 8'hFF)) begin
      drop_q <= drop_q + 8'd1;
    end
  end

  assign drop_cnt = drop_q;
`endif

  assign vector = vector_q;
  assign valid  = valid_q;
  assign full   = full_q;
  assign empty  = empty_q;
  assign count  = count_q;

endmodule
`default_nettype wire

// File: tb/tb_vector_fifo.sv
`default_nettype none
// ============================================================================
// Module   : tb_vector_fifo
// Purpose  : Self-checking bench for vector_fifo. A queue-based reference
//            model predicts vector/valid/count/full/empty/bit_ready every
//            cycle; a second instance with LSB-first order covers bit order.
// Revision : 1.0 - initial release
// ============================================================================
module tb_vector_fifo;

  localparam int unsigned VEC_W = 8;
  localparam int unsigned DEPTH = 16;
  localparam int unsigned CNT_W = $clog2(DEPTH) + 1;
  localparam int unsigned ST_W  = 1 + VEC_W + CNT_W + 3;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             flush;
  logic             bit_in;
  logic             bit_valid;
  logic             req;
  logic             bit_ready, bit_ready_l;
  logic [VEC_W-1:0] vector, vector_l;
  logic             valid, valid_l;
  logic             full, full_l;
  logic             empty, empty_l;
  logic [CNT_W-1:0] count, count_l;
`ifdef VECTOR_FIFO_DROP_CNT_EN
  logic [7:0]       drop_cnt, drop_cnt_l;
`endif

  always #5 clk = ~clk;

  vector_fifo #(.VEC_W(VEC_W), .DEPTH(DEPTH), .MSB_FIRST(1)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .bit_in(bit_in),
    .bit_valid(bit_valid), .bit_ready(bit_ready), .req(req),
    .vector(vector), .valid(valid), .full(full), .empty(empty), .count(count)
`ifdef VECTOR_FIFO_DROP_CNT_EN
    , .drop_cnt(drop_cnt)
`endif
  );

  vector_fifo #(.VEC_W(VEC_W), .DEPTH(DEPTH), .MSB_FIRST(0)) dut_lsb (
    .clk(clk), .rst_n(rst_n), .flush(flush), .bit_in(bit_in),
    .bit_valid(bit_valid), .bit_ready(bit_ready_l), .req(req),
    .vector(vector_l), .valid(valid_l), .full(full_l), .empty(empty_l),
    .count(count_l)
`ifdef VECTOR_FIFO_DROP_CNT_EN
    , .drop_cnt(drop_cnt_l)
`endif
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: stored vectors, the partial vector being assembled,
  // and the values the outputs must show after the next edge.
  logic [VEC_W-1:0] mq[$];
  logic [VEC_W-1:0] pvec;
  int               pbits;
  int               m_drop;
  logic             exp_valid;
  logic [VEC_W-1:0] exp_vec;

  function automatic logic [ST_W-1:0] exp_status();
    return {exp_valid, exp_vec, CNT_W'(mq.size()),
            mq.size() == DEPTH, mq.size() == 0, mq.size() != DEPTH};
  endfunction

  function automatic logic [ST_W-1:0] obs_status();
    return {valid, vector, count, full, empty, bit_ready};
  endfunction

  task automatic model_clear();
    mq.delete();
    pvec      = '0;
    pbits     = 0;
    m_drop    = 0;
    exp_valid = 1'b0;
    exp_vec   = '0;
  endtask

  // Drive one cycle of inputs and advance the model; returns #1 after the edge.
  task automatic step(input logic bv, input logic b, input logic rq, input logic fl);
    logic was_full, acc, pp;
    @(negedge clk);
    bit_valid = bv; bit_in = b; req = rq; flush = fl;
    was_full  = (mq.size() == DEPTH);
    acc       = bv && !was_full && !fl;
    pp        = rq && (mq.size() != 0) && !fl;
    exp_valid = pp;
    exp_vec   = pp ? mq[0] : '0;
    if (fl) m_drop = 0;
    else if (bv && was_full && m_drop < 255) m_drop++;
    if (fl) begin
      mq.delete(); pvec = '0; pbits = 0;
    end else begin
      if (pp) void'(mq.pop_front());
      if (acc) begin
        // k-th received bit (0-based) lands at position VEC_W-1-k
        pvec[VEC_W-1-pbits] = b;
        pbits++;
        if (pbits == VEC_W) begin
          mq.push_back(pvec);
          pvec = '0; pbits = 0;
        end
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic push_vec(input logic [VEC_W-1:0] v);
    for (int k = 0; k < VEC_W; k++) begin
      step(1'b1, v[VEC_W-1-k], 1'b0, 1'b0);
      n_tests++;
      if (obs_status() !== exp_status()) begin
        n_fail++;
        $display("FAIL push_status: got %h expected %h", obs_status(), exp_status());
      end
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0; bit_valid = 1'b0; bit_in = 1'b0; req = 1'b0; flush = 1'b0;
    model_clear();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    push_vec(8'h5A);
    step(1'b1, 1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b1, 1'b0);
    // asynchronous assertion away from any edge
    #2;
    rst_n = 1'b0;
    model_clear();
    #1;
    n_tests++;
    if ({valid, vector, count, full, empty} !== {1'b0, 8'h00, 5'd0, 1'b0, 1'b1}) begin
      n_fail++;
      $display("FAIL reset_async: got %h expected %h", {valid, vector, count, full, empty},
               {1'b0, 8'h00, 5'd0, 1'b0, 1'b1});
    end
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    n_tests++;
    if (bit_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_ready: got %b expected 1", bit_ready);
    end
  endtask

  task automatic test_basic();
    logic [7:0] bits;
    bits = 8'b1010_0101;
    do_reset();
    push_vec(bits);
    n_tests++;
    if (count !== 5'd1) begin
      n_fail++;
      $display("FAIL basic_count: got %0d expected 1", count);
    end
    step(1'b0, 1'b0, 1'b1, 1'b0);
    n_tests++;
    if ({valid, vector} !== {1'b1, 8'hA5}) begin
      n_fail++;
      $display("FAIL basic_pop: got %b/%h expected 1/a5", valid, vector);
    end
    n_tests++;
    if ({count, empty} !== {5'd0, 1'b1}) begin
      n_fail++;
      $display("FAIL basic_after: got %0d/%b expected 0/1", count, empty);
    end
  endtask

  task automatic test_lsb_order();
    do_reset();
    push_vec(8'b1100_0000);
    n_tests++;
    if ({count_l, empty_l, full_l, bit_ready_l} !== {5'd1, 1'b0, 1'b0, 1'b1}) begin
      n_fail++;
      $display("FAIL lsb_status: got %h expected %h",
               {count_l, empty_l, full_l, bit_ready_l}, {5'd1, 1'b0, 1'b0, 1'b1});
    end
    step(1'b0, 1'b0, 1'b1, 1'b0);
    n_tests++;
    if ({valid_l, vector_l} !== {1'b1, 8'h03}) begin
      n_fail++;
      $display("FAIL lsb_vector: got %b/%h expected 1/03", valid_l, vector_l);
    end
    n_tests++;
    if ({valid, vector} !== {1'b1, 8'hC0}) begin
      n_fail++;
      $display("FAIL msb_vector: got %b/%h expected 1/c0", valid, vector);
    end
  endtask

  task automatic test_full();
    do_reset();
    for (int i = 0; i < 16; i++) push_vec(8'(i));
    n_tests++;
    if ({full, count, bit_ready} !== {1'b1, 5'd16, 1'b0}) begin
      n_fail++;
      $display("FAIL full_flags: got %h expected %h", {full, count, bit_ready}, {1'b1, 5'd16, 1'b0});
    end
    for (int i = 0; i < 8; i++) begin
      step(1'b1, 1'($urandom), 1'b0, 1'b0);
      n_tests++;
      if (obs_status() !== exp_status()) begin
        n_fail++;
        $display("FAIL refused_status: got %h expected %h", obs_status(), exp_status());
      end
    end
`ifdef VECTOR_FIFO_DROP_CNT_EN
    n_tests++;
    if (drop_cnt !== 8'(m_drop) || m_drop != 8) begin
      n_fail++;
      $display("FAIL drop_cnt: got %0d expected 8", drop_cnt);
    end
`endif
    for (int i = 0; i < 16; i++) begin
      step(1'b0, 1'b0, 1'b1, 1'b0);
      n_tests++;
      if ({valid, vector} !== {1'b1, 8'(i)} || obs_status() !== exp_status()) begin
        n_fail++;
        $display("FAIL drain_%0d: got %h expected %h", i, obs_status(), exp_status());
      end
    end
    n_tests++;
    if (empty !== 1'b1) begin
      n_fail++;
      $display("FAIL drain_empty: got %b expected 1", empty);
    end
  endtask

  task automatic test_wrap();
    do_reset();
    for (int i = 0; i < 3; i++) push_vec(8'($urandom));
    for (int c = 0; c < 40 * VEC_W; c++) begin
      step(1'b1, 1'($urandom), (c % VEC_W) == VEC_W - 1, 1'b0);
      n_tests++;
      if (obs_status() !== exp_status() || count < 5'd3 || count > 5'd4) begin
        n_fail++;
        $display("FAIL wrap_c%0d: got %h expected %h", c, obs_status(), exp_status());
      end
    end
  endtask

  task automatic test_underflow();
    do_reset();
    for (int i = 0; i < 5; i++) begin
      step(1'b0, 1'b0, 1'b1, 1'b0);
      n_tests++;
      if ({valid, vector, count} !== {1'b0, 8'h00, 5'd0}) begin
        n_fail++;
        $display("FAIL underflow_%0d: got %h expected 0", i, {valid, vector, count});
      end
    end
  endtask

  task automatic test_flush_reset();
    for (int pass = 0; pass < 2; pass++) begin
      do_reset();
      for (int i = 0; i < 3; i++) push_vec(8'($urandom));
      for (int i = 0; i < 5; i++) step(1'b1, 1'b1, 1'b0, 1'b0);
      if (pass == 0) begin
        // flush overrides a same-cycle bit and pop
        step(1'b1, 1'b1, 1'b1, 1'b1);
      end else begin
        do_reset();
      end
      n_tests++;
      if ({count, empty, full, valid} !== {5'd0, 1'b1, 1'b0, 1'b0}) begin
        n_fail++;
        $display("FAIL clear_p%0d: got %h expected %h", pass, {count, empty, full, valid},
                 {5'd0, 1'b1, 1'b0, 1'b0});
      end
      push_vec(8'h3C);
      step(1'b0, 1'b0, 1'b1, 1'b0);
      n_tests++;
      if ({valid, vector} !== {1'b1, 8'h3C}) begin
        n_fail++;
        $display("FAIL clear_pop_p%0d: got %b/%h expected 1/3c", pass, valid, vector);
      end
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int c = 0; c < 2000; c++) begin
      logic rq;
      // first half drains slowly so the ring fills and bits are refused
      rq = (c < 1000) ? ($urandom_range(0, 29) == 0) : ($urandom_range(0, 2) == 0);
      step($urandom_range(0, 3) != 0, 1'($urandom), rq, $urandom_range(0, 199) == 0);
      n_tests++;
      if (obs_status() !== exp_status()) begin
        n_fail++;
        $display("FAIL random_c%0d: got %h expected %h", c, obs_status(), exp_status());
      end
`ifdef VECTOR_FIFO_DROP_CNT_EN
      n_tests++;
      if (drop_cnt !== 8'(m_drop)) begin
        n_fail++;
        $display("FAIL random_drop_c%0d: got %0d expected %0d", c, drop_cnt, m_drop);
      end
`endif
    end
  endtask

  initial begin
    rst_n = 1'b0; flush = 1'b0; bit_in = 1'b0; bit_valid = 1'b0; req = 1'b0;
    model_clear();
    repeat (3) @(posedge clk);
    test_reset();
    test_basic();
    test_lsb_order();
    test_full();
    test_wrap();
    test_underflow();
    test_flush_reset();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
